chorus_mem_sched: RTL and testbench
===================================

CHORUS_MEM_SCHED -- requirements
Module: chorus_mem_sched

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports: VALID  in  1  sample strobe (level, may stay high several cycles).
REQ-004 SHALL have ports: wr_data  in  16  mixed input sample to store.
REQ-005 SHALL have ports: delay_1, delay_2, delay_3  in  10 each  per-voice delay in samples (0..1023).
REQ-006 SHALL have ports: mem_addr  out  10  address to shared 1024x16 delay RAM.
REQ-007 SHALL have ports: mem_we  out  1  RAM write enable; mem_wdata  out  16  RAM write data.
REQ-008 SHALL have ports: mem_rdata  in  16  RAM read data, valid one cycle after mem_addr (synchronous read).
REQ-009 SHALL have ports: voice_1, voice_2, voice_3  out  16 each  delayed samples for the current frame.
REQ-010 SHALL have ports: voice_vld  out  1  one-cycle pulse, voices updated.
REQ-011 SHALL have ports: busy  out  1  FSM not IDLE; primed  out  1  buffer filled once; overrun  out  1  sticky dropped-frame flag.

Function
REQ-012 SHALL register VALID into valid_q each cycle; a frame start is VALID=1 with valid_q=0 at a clock edge (E0).
REQ-013 SHALL implement FSM states IDLE, WR, RD1, RD2, RD3, CAP; transitions IDLE->WR on frame start, then WR->RD1->RD2->RD3->CAP->IDLE unconditionally, one per cycle.
REQ-014 SHALL at E0 latch wr_data and delay_1..3 into internal registers; input changes after E0 SHALL NOT affect that frame.
REQ-015 SHALL in WR drive mem_we=1, mem_addr=wr_ptr, mem_wdata=latched sample; mem_we=0 in every other state.
REQ-016 SHALL in RD1/RD2/RD3 drive mem_addr=(wr_ptr - latched delay_n) mod 1024 for n=1/2/3; mem_addr=wr_ptr in IDLE and CAP.
REQ-017 SHALL capture mem_rdata into voice_1 at the edge leaving RD2, voice_2 leaving RD3, voice_3 leaving CAP.
REQ-018 SHALL force captured voice values to 16'h0000 while primed=0.
REQ-019 SHALL pulse voice_vld high for exactly the one cycle following the CAP->IDLE edge (E5); latency frame start to voice_vld = 5 cycles.
REQ-020 SHALL increment wr_ptr (10-bit, wraps 1023->0) on the CAP->IDLE edge.
REQ-021 SHALL set primed=1 on the edge where wr_ptr wraps 1023->0 and hold it until reset.
REQ-022 delay 0 SHALL return the sample written in the same frame (write precedes reads); delay 1023 SHALL return the sample written 1023 frames earlier.
REQ-023 A frame start while busy=1 SHALL be dropped (no state change, no write) and SHALL set overrun=1, sticky until reset.
REQ-024 busy SHALL be 1 in every state other than IDLE.
REQ-025 voice_1..3 SHALL hold their values between voice_vld pulses.

Reset
REQ-026 When rst_n=0 at a clock edge: state=IDLE, wr_ptr=0, valid_q=0, primed=0, overrun=0, voice_1..3=0, voice_vld=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-027 Reset mid-frame SHALL abort the frame with no voice_vld and no wr_ptr increment.
REQ-028 VALID=1 at the first edge after rst_n deasserts SHALL count as a frame start (valid_q resets to 0).

Verification
REQ-029 Single frame after reset, wr_data=16'h1234, delays 0/1/2 -> mem_we=1 addr 0 data 16'h1234 at cycle 1; reads at addr 0/1023/1022; voice_vld at cycle 5; voices all 0 (primed=0); wr_ptr=1.
REQ-030 1024 frames with wr_data=frame index -> primed rises after frame 1024; frame 1025 with delays 0/1/1023 -> voice_1=1024's sample (16'h0400), voice_2=16'h03FF, voice_3=16'h0001.
REQ-031 VALID held high 20 cycles -> exactly one frame, one voice_vld.
REQ-032 Second VALID rise 3 cycles after first -> overrun=1, only one write, one voice_vld, overrun stays 1 until reset.
REQ-033 delay_1 changed from 5 to 9 at cycle 2 of a frame -> RD1 address uses 5.
REQ-034 rst_n low during RD2 -> no voice_vld, wr_ptr=0, all outputs at reset values next cycle.

Source files
------------

// File: rtl/chorus_mem_sched.sv
// chorus_mem_sched
// Drives a shared 1024x16 delay RAM for a three-voice chorus. On each rising
// edge of VALID (a frame start), the block runs a fixed six-state frame:
//   1. Write the incoming sample at wr_ptr.
//   2. Read the RAM at wr_ptr minus each voice's delay.
//   3. Present the three delayed samples with a one-cycle voice_vld pulse.
//
// Ports:
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   VALID                  level sample strobe; only its rising edge counts
//   wr_data                sample to store for this frame
//   delay_1..3             per-voice delay in samples (0..1023)
//   mem_addr/we/wdata      RAM address, write enable and write data
//   mem_rdata              RAM read data, one cycle after mem_addr
//   voice_1..3             delayed samples; they hold between voice_vld pulses
//   voice_vld              one-cycle pulse when the voices are updated
//   busy                   a frame is in progress
//   primed                 the whole buffer has been written at least once
//   overrun                sticky; a frame start arrived while busy
module chorus_mem_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VALID,
  input  logic [15:0] wr_data,
  input  logic [9:0]  delay_1,
  input  logic [9:0]  delay_2,
  input  logic [9:0]  delay_3,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] voice_1,
  output logic [15:0] voice_2,
  output logic [15:0] voice_3,
  output logic        voice_vld,
  output logic        busy,
  output logic        primed,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD1,
    RD2,
    RD3,
    CAP
  } state_t;

  state_t      state;
  logic        valid_q;
  logic [9:0]  wr_ptr;
  logic [9:0]  d1_q;
  logic [9:0]  d2_q;
  logic [9:0]  d3_q;
  logic        frame_start;
  logic [15:0] cap_data;

  assign frame_start = VALID & ~valid_q;
  // Until the buffer has been filled once, reads return stale contents,
  // so the captured voices are silenced.
  assign cap_data    = primed ? mem_rdata : '0;

  // The outputs are registered. Each transition loads the values that belong
  // to the state being entered, so the RAM controls line up with the current
  // state without any output decode. The sample is held in mem_wdata from the
  // frame start onward; that register doubles as the latched copy of wr_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      wr_ptr    <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      voice_1   <= '0;
      voice_2   <= '0;
      voice_3   <= '0;
      voice_vld <= 1'b0;
      busy      <= 1'b0;
      primed    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid_q   <= VALID;
      voice_vld <= 1'b0;

      if (frame_start && state != IDLE)
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= WR;
            busy      <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr;
            mem_wdata <= wr_data;
            d1_q      <= delay_1;
            d2_q      <= delay_2;
            d3_q      <= delay_3;
          end
        end
        WR: begin
          state    <= RD1;
          mem_we   <= 1'b0;
          mem_addr <= wr_ptr - d1_q;
        end
        RD1: begin
          state    <= RD2;
          mem_addr <= wr_ptr - d2_q;
        end
        RD2: begin
          state    <= RD3;
          mem_addr <= wr_ptr - d3_q;
          voice_1  <= cap_data;
        end
        RD3: begin
          state    <= CAP;
          mem_addr <= wr_ptr;
          voice_2  <= cap_data;
        end
        CAP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          voice_3   <= cap_data;
          voice_vld <= 1'b1;
          wr_ptr    <= wr_ptr + 10'd1;
          mem_addr  <= wr_ptr + 10'd1;
          if (wr_ptr == '1)
            primed <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chorus_mem_sched.sv
module tb_chorus_mem_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        VALID;
  logic [15:0] wr_data;
  logic [9:0]  delay_1;
  logic [9:0]  delay_2;
  logic [9:0]  delay_3;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] voice_1;
  logic [15:0] voice_2;
  logic [15:0] voice_3;
  logic        voice_vld;
  logic        busy;
  logic        primed;
  logic        overrun;

  chorus_mem_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .VALID     (VALID),
    .wr_data   (wr_data),
    .delay_1   (delay_1),
    .delay_2   (delay_2),
    .delay_3   (delay_3),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .voice_1   (voice_1),
    .voice_2   (voice_2),
    .voice_3   (voice_3),
    .voice_vld (voice_vld),
    .busy      (busy),
    .primed    (primed),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM attached to the scheduler.
  logic [15:0] ram [1024];
  always @(posedge clk) begin
    if (mem_we)
      ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // ----------------------------------------------------------------------
  // Reference model: history of every sample stored at each address, the
  // write position, and the count of completed frames since reset.
  // ----------------------------------------------------------------------
  logic [15:0] m_hist [1024];
  int          m_ptr;
  int          m_frames;
  int          m_eptr;
  logic [15:0] m_e1, m_e2, m_e3;
  logic [15:0] m_v1, m_v2, m_v3;
  int          m_a1, m_a2, m_a3;

  function automatic int wrap(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_frames = 0;
    m_v1     = '0;
    m_v2     = '0;
    m_v3     = '0;
  endtask

  task automatic model_frame(input logic [15:0] data, input int d1, input int d2, input int d3);
    bit pr;
    pr = (m_frames >= 1024);
    m_eptr = m_ptr;
    m_hist[m_ptr] = data;
    m_a1 = wrap(m_ptr - d1);
    m_a2 = wrap(m_ptr - d2);
    m_a3 = wrap(m_ptr - d3);
    m_e1 = pr ? m_hist[m_a1] : 16'h0000;
    m_e2 = pr ? m_hist[m_a2] : 16'h0000;
    m_e3 = pr ? m_hist[m_a3] : 16'h0000;
    m_ptr = wrap(m_ptr + 1);
    m_frames++;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, " mem_we"},    32'(mem_we),    32'd0);
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, " voice_1"},   32'(voice_1),   32'd0);
    chk({tag, " voice_2"},   32'(voice_2),   32'd0);
    chk({tag, " voice_3"},   32'(voice_3),   32'd0);
    chk({tag, " voice_vld"}, 32'(voice_vld), 32'd0);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " primed"},    32'(primed),    32'd0);
    chk({tag, " overrun"},   32'(overrun),   32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    VALID = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  // One complete frame, checked cycle by cycle against the model. Inputs
  // are scrambled right after the frame start to prove they were latched.
  // With chg_d1 set, delay_1 stays put for a cycle and then changes to 9.
  task automatic run_frame(input logic [15:0] data, input logic [9:0] d1,
                           input logic [9:0] d2, input logic [9:0] d3, input bit chg_d1,
                           output logic [9:0] a1, output logic [9:0] a2, output logic [9:0] a3,
                           output logic [15:0] v1, output logic [15:0] v2, output logic [15:0] v3);
    model_frame(data, int'(d1), int'(d2), int'(d3));
    @(negedge clk);
    wr_data = data;
    delay_1 = d1;
    delay_2 = d2;
    delay_3 = d3;
    VALID   = 1'b1;
    @(negedge clk);                          // cycle 1: WR
    VALID   = 1'b0;
    wr_data = 16'($urandom);
    delay_2 = 10'($urandom);
    delay_3 = 10'($urandom);
    if (!chg_d1)
      delay_1 = 10'($urandom);
    chk("wr mem_we",    32'(mem_we),    32'd1);
    chk("wr mem_addr",  32'(mem_addr),  32'(m_eptr));
    chk("wr mem_wdata", 32'(mem_wdata), 32'(data));
    chk("wr busy",      32'(busy),      32'd1);
    chk("wr voice_vld", 32'(voice_vld), 32'd0);
    @(negedge clk);                          // cycle 2: RD1
    if (chg_d1)
      delay_1 = 10'd9;
    a1 = mem_addr;
    chk("rd1 mem_we",   32'(mem_we),   32'd0);
    chk("rd1 mem_addr", 32'(mem_addr), 32'(m_a1));
    chk("hold voice_1", 32'(voice_1),  32'(m_v1));
    chk("hold voice_2", 32'(voice_2),  32'(m_v2));
    chk("hold voice_3", 32'(voice_3),  32'(m_v3));
    @(negedge clk);                          // cycle 3: RD2
    a2 = mem_addr;
    chk("rd2 mem_addr", 32'(mem_addr), 32'(m_a2));
    @(negedge clk);                          // cycle 4: RD3
    a3 = mem_addr;
    chk("rd3 mem_addr", 32'(mem_addr), 32'(m_a3));
    @(negedge clk);                          // cycle 5: CAP
    chk("cap mem_addr",  32'(mem_addr),  32'(m_eptr));
    chk("cap busy",      32'(busy),      32'd1);
    chk("cap voice_vld", 32'(voice_vld), 32'd0);
    @(negedge clk);                          // cycle 6: voices valid
    v1 = voice_1;
    v2 = voice_2;
    v3 = voice_3;
    chk("vld voice_vld", 32'(voice_vld), 32'd1);
    chk("vld busy",      32'(busy),      32'd0);
    chk("vld voice_1",   32'(voice_1),   32'(m_e1));
    chk("vld voice_2",   32'(voice_2),   32'(m_e2));
    chk("vld voice_3",   32'(voice_3),   32'(m_e3));
    chk("idle mem_addr", 32'(mem_addr),  32'(m_ptr));
    chk("primed",        32'(primed),    32'(m_frames >= 1024));
    m_v1 = m_e1;
    m_v2 = m_e2;
    m_v3 = m_e3;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [9:0]  d1, d2, d3;
    logic [9:0]  a1, a2, a3;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [9:0]  a1, a2, a3;
    logic [15:0] v1, v2, v3;
    logic [9:0]  rd1, rd2, rd3;
    int          n_we, n_vld;

    // Frames straight after reset; read addresses follow from wr_ptr = index.
    tbl[0] = '{data: 16'h1234, d1: 10'd0, d2: 10'd1, d3: 10'd2,
               a1: 10'd0,    a2: 10'd1023, a3: 10'd1022};
    tbl[1] = '{data: 16'hA5A5, d1: 10'd5, d2: 10'd1, d3: 10'd1023,
               a1: 10'd1020, a2: 10'd0,    a3: 10'd2};
    tbl[2] = '{data: 16'h0F0F, d1: 10'd2, d2: 10'd3, d3: 10'd1000,
               a1: 10'd0,    a2: 10'd1023, a3: 10'd26};
    tbl[3] = '{data: 16'hFFFF, d1: 10'd3, d2: 10'd0, d3: 10'd512,
               a1: 10'd0,    a2: 10'd3,    a3: 10'd515};

    rst_n   = 1'b0;
    VALID   = 1'b0;
    wr_data = '0;
    delay_1 = '0;
    delay_2 = '0;
    delay_3 = '0;
    model_reset();
    do_reset();

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].data, tbl[i].d1, tbl[i].d2, tbl[i].d3, 1'b0, a1, a2, a3, v1, v2, v3);
      chk("tbl rd addr1", 32'(a1), 32'(tbl[i].a1));
      chk("tbl rd addr2", 32'(a2), 32'(tbl[i].a2));
      chk("tbl rd addr3", 32'(a3), 32'(tbl[i].a3));
      chk("tbl voice_1 unprimed", 32'(v1), 32'd0);
      chk("tbl voice_2 unprimed", 32'(v2), 32'd0);
      chk("tbl voice_3 unprimed", 32'(v3), 32'd0);
    end

    // delay_1 changes from 5 to 9 mid-frame; wr_ptr is 4, so RD1 must read 1023.
    run_frame(16'h5555, 10'd5, 10'd7, 10'd8, 1'b1, a1, a2, a3, v1, v2, v3);
    chk("late delay_1 ignored", 32'(a1), 32'd1023);

    // VALID held high for 20 cycles yields exactly one frame.
    model_frame(16'h7777, 1, 2, 3);
    @(negedge clk);
    wr_data = 16'h7777;
    delay_1 = 10'd1;
    delay_2 = 10'd2;
    delay_3 = 10'd3;
    VALID   = 1'b1;
    n_we  = 0;
    n_vld = 0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (c == 19)
        VALID = 1'b0;
      n_we  += int'(mem_we);
      n_vld += int'(voice_vld);
    end
    chk("held VALID writes",  32'(n_we),    32'd1);
    chk("held VALID vld",     32'(n_vld),   32'd1);
    chk("held VALID overrun", 32'(overrun), 32'd0);
    chk("held VALID voice_3", 32'(voice_3), 32'(m_e3));
    chk("held VALID ptr",     32'(mem_addr), 32'(m_ptr));
    m_v1 = m_e1;
    m_v2 = m_e2;
    m_v3 = m_e3;

    // A second rising edge three cycles into a frame is dropped as an overrun.
    model_frame(16'h1111, 0, 0, 0);
    @(negedge clk);
    wr_data = 16'h1111;
    delay_1 = 10'd0;
    delay_2 = 10'd0;
    delay_3 = 10'd0;
    VALID   = 1'b1;
    n_we  = 0;
    n_vld = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      n_we  += int'(mem_we);
      n_vld += int'(voice_vld);
      if (c == 1) VALID = 1'b0;
      if (c == 3) begin
        VALID   = 1'b1;
        wr_data = 16'h2222;
      end
      if (c == 4) VALID = 1'b0;
    end
    chk("overrun writes", 32'(n_we),    32'd1);
    chk("overrun vld",    32'(n_vld),   32'd1);
    chk("overrun flag",   32'(overrun), 32'd1);
    chk("overrun ptr",    32'(mem_addr), 32'(m_ptr));
    m_v1 = m_e1;
    m_v2 = m_e2;
    m_v3 = m_e3;
    run_frame(16'h3333, 10'd1, 10'd2, 10'd3, 1'b0, a1, a2, a3, v1, v2, v3);
    chk("overrun sticky", 32'(overrun), 32'd1);

    // Reset with VALID held high: the first edge after release starts a frame,
    // then a reset during RD2 aborts it.
    @(negedge clk);
    rst_n   = 1'b0;
    VALID   = 1'b1;
    wr_data = 16'hBEEF;
    delay_1 = 10'd0;
    delay_2 = 10'd0;
    delay_3 = 10'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset2");
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("post-reset start mem_we",    32'(mem_we),    32'd1);
    chk("post-reset start mem_addr",  32'(mem_addr),  32'd0);
    chk("post-reset start mem_wdata", 32'(mem_wdata), 32'hBEEF);
    m_hist[0] = 16'hBEEF;
    @(negedge clk);
    VALID = 1'b0;
    @(negedge clk);
    chk("abort in RD2 busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("abort");
    rst_n = 1'b1;
    n_vld = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vld += int'(voice_vld);
    end
    chk("abort no vld",   32'(n_vld),    32'd0);
    chk("abort wr_ptr 0", 32'(mem_addr), 32'd0);

    // Fill the buffer: frame i stores sample i, so primed rises after frame 1024.
    for (int i = 0; i < 1024; i++) begin
      rd1 = 10'($urandom);
      rd2 = 10'($urandom);
      rd3 = 10'($urandom);
      run_frame(16'(i), rd1, rd2, rd3, 1'b0, a1, a2, a3, v1, v2, v3);
    end
    chk("primed after fill", 32'(primed), 32'd1);
    run_frame(16'h0400, 10'd0, 10'd1, 10'd1023, 1'b0, a1, a2, a3, v1, v2, v3);
    chk("delay 0 sample",    32'(v1), 32'h0400);
    chk("delay 1 sample",    32'(v2), 32'h03FF);
    chk("delay 1023 sample", 32'(v3), 32'h0001);

    // Randomized frames, with delay extremes mixed in.
    for (int i = 0; i < 300; i++) begin
      rd1 = 10'($urandom);
      rd2 = 10'($urandom);
      rd3 = 10'($urandom);
      case ($urandom_range(0, 7))
        0: rd1 = 10'd0;
        1: rd2 = 10'd1023;
        2: rd3 = 10'd0;
        3: rd1 = 10'd1023;
        default: ;
      endcase
      run_frame(16'($urandom), rd1, rd2, rd3, 1'b0, a1, a2, a3, v1, v2, v3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
